// File: rtl/inst_queue.sv
// Circular instruction queue between the fetcher and the decoder.
// Buffers {pc, inst} pairs and releases one per cycle when no downstream unit is full.
module inst_queue #(
  parameter int IQ_SIZE   = 16,
  parameter int IQ_ADDR_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_input_valid,
  input  logic [DATA_W-1:0] IF_inst,
  input  logic [DATA_W-1:0] IF_inst_pc,
  output logic              IF_IQ_is_full,
  input  logic              RS_is_full,
  input  logic              ROB_is_full,
  input  logic              LSB_is_full,
  output logic              ID_output_valid,
  output logic [DATA_W-1:0] ID_inst,
  output logic [DATA_W-1:0] ID_inst_pc,
  input  logic              ROB_roll_back_flag
);

  localparam logic [IQ_ADDR_W:0]   FULL_CNT = (IQ_ADDR_W + 1)'(IQ_SIZE);
  localparam logic [IQ_ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [IQ_ADDR_W-1:0] PTR_ONE  = 1;

  logic [DATA_W-1:0]    inst_mem_q [IQ_SIZE];
  logic [DATA_W-1:0]    pc_mem_q   [IQ_SIZE];

  logic [IQ_ADDR_W-1:0] head_q, head_d;
  logic [IQ_ADDR_W-1:0] tail_q, tail_d;
  logic [IQ_ADDR_W:0]   count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_inst_q, out_inst_d;
  logic [DATA_W-1:0]    out_pc_q, out_pc_d;

  logic full, empty, stall, push, pop;

  // Full is taken from the registered count, so a same-cycle pop never admits a push.
  always_comb begin
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    stall       = RS_is_full | ROB_is_full | LSB_is_full;
    push        = 1'b0;
    pop         = 1'b0;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;

    if (ROB_roll_back_flag) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      out_inst_d = '0;
      out_pc_d   = '0;
    end else if (rdy) begin
      push = IF_input_valid & ~full;
      pop  = ~empty & ~stall;
      if (push) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (pop) begin
        head_d      = head_q + PTR_ONE;
        out_inst_d  = inst_mem_q[head_q];
        out_pc_d    = pc_mem_q[head_q];
        out_valid_d = 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem_q[tail_q] <= IF_inst;
      pc_mem_q[tail_q]   <= IF_inst_pc;
    end
  end

  assign IF_IQ_is_full   = full;
  assign ID_output_valid = out_valid_q;
  assign ID_inst         = out_inst_q;
  assign ID_inst_pc      = out_pc_q;

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: directed scenarios plus a random run checked
// against a queue-based model of the instruction queue.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, if_valid, rs_full, rob_full, lsb_full, roll_back;
  logic [31:0] if_inst, if_pc;
  logic        iq_full, id_valid;
  logic [31:0] id_inst, id_pc;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_q[$];
  logic        m_valid;
  logic [31:0] m_inst, m_pc;

  inst_queue #(.IQ_SIZE(16), .IQ_ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IF_input_valid(if_valid), .IF_inst(if_inst), .IF_inst_pc(if_pc),
    .IF_IQ_is_full(iq_full),
    .RS_is_full(rs_full), .ROB_is_full(rob_full), .LSB_is_full(lsb_full),
    .ID_output_valid(id_valid), .ID_inst(id_inst), .ID_inst_pc(id_pc),
    .ROB_roll_back_flag(roll_back)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the behavioural model, then settle to sample point.
  task automatic step();
    logic was_full, do_pop;
    @(posedge clk);
    if (rst || roll_back) begin
      m_q.delete();
      m_valid = 1'b0;
      m_inst  = '0;
      m_pc    = '0;
    end else if (!rdy) begin
      m_valid = 1'b0;
    end else begin
      was_full = (m_q.size() == 16);
      do_pop   = (m_q.size() != 0) && !(rs_full || rob_full || lsb_full);
      if (do_pop) begin
        {m_pc, m_inst} = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (if_valid && !was_full) m_q.push_back({if_pc, if_inst});
    end
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 0; rs_full = 0; rob_full = 0; lsb_full = 0; roll_back = 0; rdy = 1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); if_inst = '0; if_pc = '0;
    step(); step();
    rst = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", id_pc); end
    checks++; if (iq_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", iq_full); end
  endtask

  task automatic test_latency();
    if_valid = 1; if_pc = 32'h0; if_inst = 32'h00500093;
    step();
    if_valid = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge1: got %b expected 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_edge2_valid: got %b expected 1", id_valid); end
    checks++; if (id_inst !== 32'h00500093) begin errors++; $display("[TB] FAIL latency_inst: got %h expected 00500093", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL latency_pc: got %h expected 0", id_pc); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge3: got %b expected 0", id_valid); end
  endtask

  task automatic test_fill_full();
    logic [31:0] insts[16];
    rs_full = 1;
    for (int i = 0; i < 16; i++) begin
      insts[i] = $urandom;
      if_valid = 1; if_pc = 32'(4 * i); if_inst = insts[i];
      step();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_output[%0d]: got %b expected 0", i, id_valid); end
    end
    checks++; if (iq_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full_after16: got %b expected 1", iq_full); end
    if_pc = 32'd64; if_inst = 32'hbad0bad0;
    step();
    if_valid = 0;
    checks++; if (iq_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full_after_drop: got %b expected 1", iq_full); end
    rs_full = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_inst !== insts[i]) begin
        errors++;
        $display("[TB] FAIL drain[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 i, id_valid, id_pc, id_inst, 32'(4 * i), insts[i]);
      end
    end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_valid: got %b expected 0 (pc 64 leaked?)", id_valid); end
    checks++; if (iq_full !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_full: got %b expected 0", iq_full); end
  endtask

  task automatic test_wrap_stream();
    logic [31:0] exp_pc;
    for (int k = 0; k < 42; k++) begin
      if_valid = (k < 40);
      if_pc    = 32'h1000 + 32'(4 * k);
      if_inst  = if_pc ^ 32'hdeadbeef;
      step();
      exp_pc = 32'h1000 + 32'(4 * (k - 1));
      checks++;
      if (k >= 1 && k <= 40) begin
        if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== (exp_pc ^ 32'hdeadbeef) || iq_full !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stream[%0d]: got v=%b pc=%h inst=%h full=%b expected v=1 pc=%h inst=%h full=0",
                   k, id_valid, id_pc, id_inst, iq_full, exp_pc, exp_pc ^ 32'hdeadbeef);
        end
      end else if (id_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_idle[%0d]: got v=%b expected 0", k, id_valid);
      end
    end
    if_valid = 0;
  endtask

  task automatic test_stall_mix();
    logic [1:0] pat[6]  = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    logic       exp_v[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int n = 0;
    rs_full = 1;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; if_pc = 32'h2000 + 32'(4 * i); if_inst = 32'h5a000000 + 32'(i);
      step();
    end
    if_valid = 0; rs_full = 0;
    for (int c = 0; c < 6; c++) begin
      rob_full = pat[c][1]; lsb_full = pat[c][0];
      step();
      checks++;
      if (id_valid !== exp_v[c]) begin
        errors++;
        $display("[TB] FAIL stall_valid[%0d]: got %b expected %b", c, id_valid, exp_v[c]);
      end else if (exp_v[c]) begin
        if (id_pc !== 32'h2000 + 32'(4 * n) || id_inst !== 32'h5a000000 + 32'(n)) begin
          errors++;
          $display("[TB] FAIL stall_order[%0d]: got pc=%h inst=%h expected pc=%h", c, id_pc, id_inst, 32'h2000 + 32'(4 * n));
        end
        n++;
      end
    end
    rob_full = 0; lsb_full = 0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_dup: got %b expected 0", id_valid); end
  endtask

  task automatic test_roll_back();
    rs_full = 1;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1; if_pc = 32'h80 + 32'(4 * i); if_inst = $urandom;
      step();
    end
    rs_full = 0; roll_back = 1; if_pc = 32'h100; if_inst = 32'h11111111;
    step();
    roll_back = 0; if_valid = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rb_valid: got %b expected 0", id_valid); end
    checks++; if (iq_full !== 1'b0) begin errors++; $display("[TB] FAIL rb_full: got %b expected 0", iq_full); end
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("[TB] FAIL rb_clear: got pc=%h inst=%h expected 0", id_pc, id_inst); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rb_empty: got v=%b pc=%h expected v=0", id_valid, id_pc); end
    if_valid = 1; if_pc = 32'h200; if_inst = 32'h22222222;
    step();
    if_valid = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rb_push_early: got %b expected 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin errors++; $display("[TB] FAIL rb_push_emit: got v=%b pc=%h expected v=1 pc=00000200", id_valid, id_pc); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rb_after: got %b expected 0", id_valid); end
  endtask

  task automatic test_rdy_freeze();
    rs_full = 1;
    for (int i = 0; i < 2; i++) begin
      if_valid = 1; if_pc = 32'h300 + 32'(4 * i); if_inst = 32'h77000000 + 32'(i);
      step();
    end
    rs_full = 0; rdy = 0; if_valid = 1; if_pc = 32'h400; if_inst = 32'h44444444;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (id_valid !== 1'b0 || id_pc !== m_pc || iq_full !== 1'b0) begin
        errors++;
        $display("[TB] FAIL freeze[%0d]: got v=%b pc=%h full=%b expected v=0 pc=%h full=0", c, id_valid, id_pc, iq_full, m_pc);
      end
    end
    rdy = 1; if_valid = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h300 + 32'(4 * i) || id_inst !== 32'h77000000 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL thaw[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h", i, id_valid, id_pc, id_inst, 32'h300 + 32'(4 * i));
      end
    end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL thaw_end: got v=%b pc=%h expected v=0", id_valid, id_pc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      roll_back = ($urandom_range(0, 49) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      if_valid  = ($urandom_range(0, 3) != 0);
      rs_full   = ($urandom_range(0, 4) == 0);
      rob_full  = ($urandom_range(0, 6) == 0);
      lsb_full  = ($urandom_range(0, 8) == 0);
      if_inst   = $urandom;
      if_pc     = $urandom;
      step();
      checks++;
      if (id_valid !== m_valid || id_inst !== m_inst || id_pc !== m_pc || iq_full !== (m_q.size() == 16)) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got v=%b inst=%h pc=%h full=%b expected v=%b inst=%h pc=%h full=%b",
                 c, id_valid, id_inst, id_pc, iq_full, m_valid, m_inst, m_pc, m_q.size() == 16);
      end
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    m_valid = 0; m_inst = '0; m_pc = '0;
    test_reset();
    test_latency();
    test_fill_full();
    test_wrap_stream();
    test_stall_mix();
    test_roll_back();
    test_rdy_freeze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO of fetched instructions between the instruction fetcher and the decoder.
- Buffers {pc, inst} pairs pushed by the fetcher.
- Releases one entry per cycle to the decoder, but only when no downstream structure (reservation station, ROB, load/store buffer) reports full.
- Flushed completely on ROB roll back.

Parameters:
- IQ_SIZE, 16, number of entries (power of two).
- IQ_ADDR_W, 4, log2(IQ_SIZE); pointer width.
- DATA_W, 32, instruction and pc width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low = freeze.
- IF_input_valid  in  1  fetcher presents a new instruction this cycle.
- IF_inst  in  DATA_W  instruction word.
- IF_inst_pc  in  DATA_W  pc of instruction.
- IF_IQ_is_full  out  1  combinational; queue cannot accept a push this cycle.
- RS_is_full  in  1  reservation station cannot accept (from IQ_RS_is_full).
- ROB_is_full  in  1  reorder buffer cannot accept.
- LSB_is_full  in  1  load/store buffer cannot accept.
- ID_output_valid  out  1  registered; ID_inst/ID_inst_pc valid this cycle.
- ID_inst  out  DATA_W  registered instruction to decoder.
- ID_inst_pc  out  DATA_W  registered pc to decoder.
- ROB_roll_back_flag  in  1  misprediction flush.

Behaviour:
State:
- head and tail pointers, IQ_ADDR_W bits each, wrap modulo IQ_SIZE.
- count, IQ_ADDR_W+1 bits, range 0..IQ_SIZE.
- Entry arrays inst[] and pc[].

Internal signals:
- full = (count == IQ_SIZE).
- empty = (count == 0).
- stall = RS_is_full | ROB_is_full | LSB_is_full.
- IF_IQ_is_full = full, a pure function of registered count, so it carries no input dependency.

Priority at each posedge, in this order:
1. rst or ROB_roll_back_flag:
   - head = tail = count = 0; ID_output_valid = 0; ID_inst = 0; ID_inst_pc = 0.
   - Any same-cycle push is discarded.
   - The entry arrays need not be cleared.
2. rdy == 0:
   - Pointers, count and arrays hold; no push or pop.
   - ID_output_valid = 0, so nothing is consumed twice while frozen; ID_inst/ID_inst_pc hold.
3. Otherwise, compute:
   - push = IF_input_valid & ~full.
   - pop = ~empty & ~stall.
   - Push: inst[tail] = IF_inst; pc[tail] = IF_inst_pc; tail = tail + 1.
   - Pop: ID_inst = inst[head]; ID_inst_pc = pc[head]; head = head + 1; ID_output_valid = 1.
   - No pop: ID_output_valid = 0; ID_inst/ID_inst_pc hold.
   - count update: count + push - pop.

Timing and boundary rules:
- Latency: an instruction pushed at edge N is popped at edge N+1 at the earliest, so ID_output_valid is first high in the cycle after edge N+1. There is no empty bypass.
- Throughput: one push and one pop per cycle. Simultaneous push and pop leaves count unchanged, including when count == IQ_SIZE-1 or count == 1.
- Push while full: the push is rejected and the data is dropped. The fetcher must hold the instruction and retry. A pop in the same cycle does not let the push in, because full is evaluated from pre-edge count.
- Pop while empty: no action; ID_output_valid = 0.
- stall only blocks pops; pushes proceed.
- Wrap-around: pointers wrap from IQ_SIZE-1 to 0 with no bubble.
- Order is strict FIFO and is never reordered.

Reset values: IF_IQ_is_full = 0 (count = 0), ID_output_valid = 0, ID_inst = 0, ID_inst_pc = 0.

Test Plan:
- Basic latency:
  - Stimulus: reset; push pc=0x0 inst=0x00500093 at edge 1; no stall.
  - Required: ID_output_valid = 1 after edge 2 only, with ID_inst = 0x00500093 and ID_inst_pc = 0x0; low after edge 3.
- Fill and full:
  - Stimulus: RS_is_full = 1; push 16 instructions pc = 0, 4, …, 60; then attempt pc = 64.
  - Required: IF_IQ_is_full = 1 after the 16th push; pc 64 is dropped; count stays 16.
  - Then release RS_is_full: 16 consecutive ID_output_valid cycles with pc 0..60 in order.
- Wrap and simultaneous push/pop:
  - Stimulus: stream 40 instructions at one per cycle with no stall.
  - Required: after the first output, outputs are back to back in pc order; count never exceeds 1; correct across both pointer wraps.
- Stall mix:
  - Stimulus: 3 entries queued; pulse ROB_is_full for 2 cycles, then LSB_is_full for 1 cycle.
  - Required: ID_output_valid = 0 exactly during stall cycles; the 3 outputs keep order with no duplicates.
- Roll back:
  - Stimulus: 5 entries queued; assert ROB_roll_back_flag together with IF_input_valid (pc = 0x100).
  - Required: next cycle count = 0, ID_output_valid = 0, IF_IQ_is_full = 0; pc 0x100 is never emitted.
  - A subsequent push of pc = 0x200 emits 2 cycles later.
- rdy freeze:
  - Stimulus: 2 entries queued; rdy = 0 for 3 cycles while IF_input_valid = 1.
  - Required: no output and no pushes during the freeze; after rdy = 1 the original 2 entries emit in order.
